alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `ALU` instance between `N_REQ` requesters. Each requester presents operands and an op code on a valid/ready channel. The block grants one requester, registers its operands into the ALU input ports, captures the ALU result and flags, and returns them with the requester ID on a single shared response channel. It sits between the requesting units and the combinational ALU, which is instantiated alongside it and wired to its `o_alu_*` / `i_alu_*` ports.

---
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU among N_REQ requesters.
// Optional op code legality check: define ALU_ARB_OPCODE_CHECK_EN.
module alu_arbiter #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP_CODE = 6,
  parameter int N_REQ      = 4,
  parameter int NB_ID      = $clog2(N_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ*NB_DATA-1:0]   i_req_data_a,
  input  logic [N_REQ*NB_DATA-1:0]   i_req_data_b,
  input  logic [N_REQ*NB_OP_CODE-1:0] i_req_op_code,
  output logic [NB_DATA-1:0]         o_alu_data_a,
  output logic [NB_DATA-1:0]         o_alu_data_b,
  output logic [NB_OP_CODE-1:0]      o_alu_op_code,
  input  logic [NB_DATA-1:0]         i_alu_result,
  input  logic                       i_alu_zero,
  input  logic                       i_alu_carry,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [NB_ID-1:0]           o_rsp_id,
  output logic [NB_DATA-1:0]         o_rsp_result,
  output logic                       o_rsp_zero,
  output logic                       o_rsp_carry,
  output logic                       o_rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic [NB_ID-1:0]  last_grant;
  logic [NB_ID-1:0]  win_id;
  logic [NB_ID-1:0]  op_id;
  logic              win_found;
  logic [N_REQ-1:0]  rot;
  int unsigned       idx;
  logic              op_illegal;

  // Search starts one past the last grant and wraps; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rot       = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(last_grant) + i) % N_REQ;
      rot = i_req_valid >> idx;
      if (!win_found && rot[0]) begin
        win_found = 1'b1;
        win_id    = NB_ID'(idx);
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (i_rst_n && state == IDLE && win_found)
      o_req_ready = N_REQ'(1) << win_id;
  end

`ifdef ALU_ARB_OPCODE_CHECK_EN
  always_comb begin
    case (o_alu_op_code)
      NB_OP_CODE'(6'b100000), NB_OP_CODE'(6'b100010), NB_OP_CODE'(6'b100100),
      NB_OP_CODE'(6'b100101), NB_OP_CODE'(6'b100110), NB_OP_CODE'(6'b000011),
      NB_OP_CODE'(6'b000010), NB_OP_CODE'(6'b100111): op_illegal = 1'b0;
      default:                                        op_illegal = 1'b1;
    endcase
  end
`else
  assign op_illegal = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      last_grant    <= NB_ID'(N_REQ - 1);
      op_id         <= '0;
      o_alu_data_a  <= '0;
      o_alu_data_b  <= '0;
      o_alu_op_code <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_id      <= '0;
      o_rsp_result  <= '0;
      o_rsp_zero    <= 1'b0;
      o_rsp_carry   <= 1'b0;
      o_rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            o_alu_data_a  <= NB_DATA'(i_req_data_a >> (32'(win_id) * NB_DATA));
            o_alu_data_b  <= NB_DATA'(i_req_data_b >> (32'(win_id) * NB_DATA));
            o_alu_op_code <= NB_OP_CODE'(i_req_op_code >> (32'(win_id) * NB_OP_CODE));
            op_id         <= win_id;
            last_grant    <= win_id;
            state         <= EXEC;
          end
        end
        EXEC: begin
          o_rsp_valid <= 1'b1;
          o_rsp_id    <= op_id;
          o_rsp_err   <= op_illegal;
          if (op_illegal) begin
            o_rsp_result <= '0;
            o_rsp_zero   <= 1'b0;
            o_rsp_carry  <= 1'b0;
          end else begin
            o_rsp_result <= i_alu_result;
            o_rsp_zero   <= i_alu_zero;
            o_rsp_carry  <= i_alu_carry;
          end
          state <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter against a transaction-level model, with a
// behavioural ALU attached to the o_alu_*/i_alu_* ports.
module tb_alu_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       tv[N];
  logic [7:0] ta[N];
  logic [7:0] db[N];
  logic [5:0] top[N];
  logic       rsp_ready;

  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [23:0] req_op;
  assign req_valid = {tv[3], tv[2], tv[1], tv[0]};
  assign req_a     = {ta[3], ta[2], ta[1], ta[0]};
  assign req_b     = {db[3], db[2], db[1], db[0]};
  assign req_op    = {top[3], top[2], top[1], top[0]};

  logic [3:0] o_req_ready;
  logic [7:0] o_alu_a, o_alu_b, alu_result, o_rsp_result;
  logic [5:0] o_alu_op;
  logic       alu_zero, alu_carry, o_rsp_valid, o_rsp_zero, o_rsp_carry, o_rsp_err;
  logic [1:0] o_rsp_id;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.NB_DATA(8), .NB_OP_CODE(6), .N_REQ(N), .NB_ID(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready),
    .i_req_data_a(req_a), .i_req_data_b(req_b), .i_req_op_code(req_op),
    .o_alu_data_a(o_alu_a), .o_alu_data_b(o_alu_b), .o_alu_op_code(o_alu_op),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero), .i_alu_carry(alu_carry),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(o_rsp_id),
    .o_rsp_result(o_rsp_result), .o_rsp_zero(o_rsp_zero),
    .o_rsp_carry(o_rsp_carry), .o_rsp_err(o_rsp_err)
  );

  // Returns {carry, zero, result}.
  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [8:0] w;
    logic [7:0] s;
    s = $signed(a) >>> b[2:0];
    case (op)
      6'b100000: w = {1'b0, a} + {1'b0, b};
      6'b100010: w = {1'b0, a} - {1'b0, b};
      6'b100100: w = {1'b0, a & b};
      6'b100101: w = {1'b0, a | b};
      6'b100110: w = {1'b0, a ^ b};
      6'b000011: w = {1'b0, s};
      6'b000010: w = {1'b0, a >> b[2:0]};
      6'b100111: w = {1'b0, ~(a | b)};
      default:   w = '0;
    endcase
    return {w[8], (w[7:0] == 8'h00), w[7:0]};
  endfunction

  always_comb {alu_carry, alu_zero, alu_result} = alu_f(o_alu_a, o_alu_b, o_alu_op);

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                      6'b100110, 6'b000011, 6'b000010, 6'b100111};
  endfunction

`ifdef ALU_ARB_OPCODE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Returns {err, carry, zero, result} as the response channel must show it.
  function automatic logic [10:0] model_rsp(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    if (CHK && !legal_op(op)) return 11'b100_0000_0000;
    return {1'b0, alu_f(a, b, op)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks every cycle against the transaction model.
  initial begin : cmp
    int cyc, acc, last, win, eid;
    bit busy;
    logic [7:0]  ea, eb;
    logic [5:0]  eop;
    logic [10:0] e;
    logic [3:0]  er;
    logic        exp_rv;
    cyc = 0; acc = 0; last = N - 1; busy = 0; eid = 0;
    ea = '0; eb = '0; eop = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_req_ready", o_req_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_id", o_rsp_id, 0);
        check("rst_rsp_result", o_rsp_result, 0);
        check("rst_rsp_flags", {o_rsp_zero, o_rsp_carry, o_rsp_err}, 0);
        check("rst_alu", {o_alu_a, o_alu_b, o_alu_op}, 0);
        busy = 0;
        last = N - 1;
      end else begin
        cyc++;
        win = -1;
        if (!busy)
          for (int i = 1; i <= N; i++)
            if (win < 0 && tv[(last + i) % N]) win = (last + i) % N;
        er = (win >= 0) ? 4'(1 << win) : 4'b0000;
        check("req_ready", o_req_ready, er);
        exp_rv = busy && (cyc >= acc + 2);
        check("rsp_valid", o_rsp_valid, exp_rv);
        if (busy && cyc == acc + 1) begin
          check("alu_a", o_alu_a, ea);
          check("alu_b", o_alu_b, eb);
          check("alu_op", o_alu_op, eop);
        end
        if (exp_rv) begin
          e = model_rsp(ea, eb, eop);
          check("rsp_id", o_rsp_id, eid);
          check("rsp_result", o_rsp_result, e[7:0]);
          check("rsp_zero", o_rsp_zero, e[8]);
          check("rsp_carry", o_rsp_carry, e[9]);
          check("rsp_err", o_rsp_err, e[10]);
        end
        if (exp_rv && rsp_ready) busy = 0;
        else if (win >= 0) begin
          busy = 1; acc = cyc; last = win; eid = win;
          ea = ta[win]; eb = db[win]; eop = top[win];
        end
      end
    end
  end

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      tv[i] = 1'b0; ta[i] = '0; db[i] = '0; top[i] = '0;
    end
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    tv[k] = 1'b1; ta[k] = a; db[k] = b; top[k] = op;
  endtask

  task automatic run_one(input int k, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         input logic [7:0] er, input logic ez, input logic ec, input logic ee,
                         input string tag);
    int n;
    @(posedge clk); #1;
    clear_reqs(); set_req(k, a, b, op); rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (o_req_ready !== 4'(1 << k) && n < 20);
    check({tag, "_grant"}, o_req_ready, 4'(1 << k));
    @(posedge clk); #1 clear_reqs();
    n = 1;
    @(negedge clk);
    while (o_rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_latency"}, n, 2);
    check({tag, "_id"}, o_rsp_id, k);
    check({tag, "_result"}, o_rsp_result, er);
    check({tag, "_zero"}, o_rsp_zero, ez);
    check({tag, "_carry"}, o_rsp_carry, ec);
    check({tag, "_err"}, o_rsp_err, ee);
    @(posedge clk);
  endtask

  logic [5:0] ops[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                         6'b100110, 6'b000011, 6'b000010, 6'b100111};

  initial begin : stim
    int n;
    int g[$];
    logic [7:0] snap_res;
    logic [1:0] snap_id;
    clear_reqs();
    rsp_ready = 1'b0;
    #2;
    check("reset_ready", o_req_ready, 0);
    check("reset_valid", o_rsp_valid, 0);
    check("reset_alu_a", o_alu_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_one(0, 8'h0F, 8'h01, 6'b100000, 8'h10, 1'b0, 1'b0, 1'b0, "add");
    run_one(2, 8'hFF, 8'h01, 6'b100000, 8'h00, 1'b1, 1'b1, 1'b0, "addc");
`ifdef ALU_ARB_OPCODE_CHECK_EN
    run_one(1, 8'h12, 8'h34, 6'b111111, 8'h00, 1'b0, 1'b0, 1'b1, "illegal");
`else
    run_one(1, 8'h12, 8'h34, 6'b111111, 8'h00, 1'b1, 1'b0, 1'b0, "illegal");
`endif

    // Reset pulse while a transaction is in EXEC.
    @(posedge clk); #1;
    clear_reqs(); set_req(3, 8'h55, 8'h0A, 6'b100000); rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (o_req_ready !== 4'b1000 && n < 20);
    check("mid_grant", o_req_ready, 4'b1000);
    @(posedge clk); #1 clear_reqs();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_rsp_valid, 0);
    check("mid_rst_id", o_rsp_id, 0);
    check("mid_rst_alu", {o_alu_a, o_alu_b, o_alu_op}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fairness: all requesters valid continuously.
    for (int k = 0; k < N; k++) set_req(k, 8'(k * 16 + 3), 8'(k + 1), ops[k]);
    n = 0;
    while (g.size() < 5 && n < 60) begin
      @(negedge clk); n++;
      if (o_req_ready != 4'b0000) g.push_back($clog2(o_req_ready));
    end
    for (int i = 0; i < 5; i++)
      check("fair_order", (i < g.size()) ? g[i] : -1, i % N);

    // Backpressure with all requesters still asking.
    @(posedge clk); #1 rsp_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (o_rsp_valid !== 1'b1 && n < 20);
    check("bp_valid", o_rsp_valid, 1);
    snap_res = o_rsp_result;
    snap_id  = o_rsp_id;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_low", o_req_ready, 0);
      check("bp_hold_valid", o_rsp_valid, 1);
      check("bp_hold_id", o_rsp_id, snap_id);
      check("bp_hold_result", o_rsp_result, snap_res);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", o_rsp_valid, 0);
    check("bp_release_idle", |o_req_ready, 1);

    // Randomized traffic.
    repeat (600) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        tv[k]  = 1'($urandom_range(0, 1));
        ta[k]  = 8'($urandom);
        db[k]  = 8'($urandom);
        top[k] = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    @(posedge clk); #1 clear_reqs(); rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
